// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: func3 access encodings and FSM states.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsuState_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication and byte enables, load extraction
// and extension, plus misalignment and illegal-func3 detection.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        isStore,
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] storeData,
  input  logic [31:0] busRdata,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  output logic [31:0] loadWord,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] byteShift;
  logic [31:0] halfShift;

  assign byteShift = busRdata >> {offset, 3'b000};
  assign halfShift = busRdata >> {offset[1], 4'b0000};

  always_comb begin
    busWdata   = storeData;
    busBe      = 4'b1111;
    loadWord   = busRdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (isStore) begin
      case (func3)
        F3_SB: begin
          busWdata = {4{storeData[7:0]}};
          busBe    = 4'b0001 << offset;
        end
        F3_SH: begin
          busWdata   = {2{storeData[15:0]}};
          busBe      = 4'b0011 << offset;
          misaligned = offset[0];
        end
        F3_SW:   misaligned = (offset != 2'b00);
        default: illegal = 1'b1;
      endcase
    end else begin
      case (func3)
        F3_LB:  loadWord = {{24{byteShift[7]}}, byteShift[7:0]};
        F3_LBU: loadWord = {24'h000000, byteShift[7:0]};
        F3_LH: begin
          loadWord   = {{16{halfShift[15]}}, halfShift[15:0]};
          misaligned = offset[0];
        end
        F3_LHU: begin
          loadWord   = {16'h0000, halfShift[15:0]};
          misaligned = offset[0];
        end
        F3_LW:   misaligned = (offset != 2'b00);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: edge-detected request accept, single-outstanding
// req/ack bus transaction with timeout, and done/fault reporting to control.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dMemRead,
  input  logic              dMemWrite,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       storeData,
  output logic [31:0]       loadData,
  output logic              done,
  output logic              fault,
  output logic              busy,
  output logic              busReq,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [31:0]       busWdata,
  output logic [3:0]        busBe,
  input  logic              busAck,
  input  logic [31:0]       busRdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsuState_e         state_q, state_d;
  logic              prevReq_q, prevReq_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              faultLatch_q, faultLatch_d;
  logic [31:0]       loadData_q, loadData_d;
  logic              busReq_q, busReq_d;
  logic              busWe_q, busWe_d;
  logic [ADDR_W-1:0] busAddr_q, busAddr_d;
  logic [31:0]       busWdata_q, busWdata_d;
  logic [3:0]        busBe_q, busBe_d;
  logic              isStore_q, isStore_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        offset_q, offset_d;

  logic        reqLevel, start, inIdle;
  logic        alignStore;
  logic [2:0]  alignFunc3;
  logic [1:0]  alignOffset;
  logic [31:0] alignWdata, alignLoad;
  logic [3:0]  alignBe;
  logic        alignMis, alignIll;

  assign reqLevel = dMemRead | dMemWrite;
  assign inIdle   = (state_q == IDLE);
  assign start    = reqLevel & ~prevReq_q & inIdle;

  // Decode the live request while idle; during a transaction use the latched one.
  assign alignStore  = inIdle ? dMemWrite : isStore_q;
  assign alignFunc3  = inIdle ? func3 : func3_q;
  assign alignOffset = inIdle ? addr[1:0] : offset_q;

  lsu_align uAlign (
    .isStore   (alignStore),
    .func3     (alignFunc3),
    .offset    (alignOffset),
    .storeData (storeData),
    .busRdata  (busRdata),
    .busWdata  (alignWdata),
    .busBe     (alignBe),
    .loadWord  (alignLoad),
    .misaligned(alignMis),
    .illegal   (alignIll)
  );

  always_comb begin
    state_d      = state_q;
    prevReq_d    = reqLevel;
    count_d      = count_q;
    faultLatch_d = faultLatch_q;
    loadData_d   = loadData_q;
    busReq_d     = busReq_q;
    busWe_d      = busWe_q;
    busAddr_d    = busAddr_q;
    busWdata_d   = busWdata_q;
    busBe_d      = busBe_q;
    isStore_d    = isStore_q;
    func3_d      = func3_q;
    offset_d     = offset_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          if ((dMemRead & dMemWrite) | alignMis | alignIll) begin
            faultLatch_d = 1'b1;
            state_d      = RESP;
          end else begin
            faultLatch_d = 1'b0;
            busReq_d     = 1'b1;
            busWe_d      = dMemWrite;
            busAddr_d    = {addr[ADDR_W-1:2], 2'b00};
            busWdata_d   = alignWdata;
            busBe_d      = alignBe;
            isStore_d    = dMemWrite;
            func3_d      = func3;
            offset_d     = addr[1:0];
            state_d      = ACCESS;
          end
        end
      end
      ACCESS: begin
        count_d = count_q + 1'b1;
        if (busAck) begin
          busReq_d = 1'b0;
          if (!isStore_q) loadData_d = alignLoad;
          state_d = RESP;
        end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          busReq_d     = 1'b0;
          faultLatch_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      prevReq_q    <= 1'b0;
      count_q      <= '0;
      faultLatch_q <= 1'b0;
      loadData_q   <= '0;
      busReq_q     <= 1'b0;
      busWe_q      <= 1'b0;
      busAddr_q    <= '0;
      busWdata_q   <= '0;
      busBe_q      <= '0;
      isStore_q    <= 1'b0;
      func3_q      <= '0;
      offset_q     <= '0;
    end else begin
      state_q      <= state_d;
      prevReq_q    <= prevReq_d;
      count_q      <= count_d;
      faultLatch_q <= faultLatch_d;
      loadData_q   <= loadData_d;
      busReq_q     <= busReq_d;
      busWe_q      <= busWe_d;
      busAddr_q    <= busAddr_d;
      busWdata_q   <= busWdata_d;
      busBe_q      <= busBe_d;
      isStore_q    <= isStore_d;
      func3_q      <= func3_d;
      offset_q     <= offset_d;
    end
  end

  assign loadData = loadData_q;
  assign done     = (state_q == RESP);
  assign fault    = (state_q == RESP) & faultLatch_q;
  assign busy     = ~inIdle;
  assign busReq   = busReq_q;
  assign busWe    = busWe_q;
  assign busAddr  = busAddr_q;
  assign busWdata = busWdata_q;
  assign busBe    = busBe_q;

endmodule
